// File: rtl/div_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : div_pkg
//  Purpose  : Shared definitions for the divider request front-end:
//             FSM state encodings and out_err result codes.
//  Ports    : none (package)
//  Revision : 1.0  initial release
// ============================================================================
package div_pkg;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        WAIT_IDLE = 3'd1,
        LAUNCH    = 3'd2,
        BUSY      = 3'd3,
        RESULT    = 3'd4
    } state_t;

    localparam logic [1:0] ERR_NONE    = 2'b00;
    localparam logic [1:0] ERR_TIMEOUT = 2'b01;
    localparam logic [1:0] ERR_DIV0    = 2'b10;

endpackage
`default_nettype wire

// File: rtl/div_req_watchdog.sv
`default_nettype none
// ============================================================================
//  Module   : div_req_watchdog
//  Purpose  : Cycle counter bounding how long the front-end waits for the
//             divider's DONE. Cleared while launching, counts while busy and
//             flags expiry on the TIMEOUT-th busy cycle.
//  Ports    : clk     - system clock, rising edge
//             rst     - asynchronous reset, active-low
//             clear   - zero the counter
//             enable  - advance the counter by one this cycle
//             expire  - counter has reached TIMEOUT-1 while enabled
//  Revision : 1.0  initial release
// ============================================================================
module div_req_watchdog #(
    parameter int TIMEOUT = 64
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic enable,
    output logic expire
);

    localparam int CNT_W = $clog2(TIMEOUT) + 1;

    logic [CNT_W-1:0] r_count;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_count <= '0;
        end else if (clear) begin
            r_count <= '0;
        end else if (enable) begin
            r_count <= r_count + CNT_W'(1);
        end
    end

    assign expire = enable && (r_count == CNT_W'(TIMEOUT - 1));

endmodule
`default_nettype wire

// File: rtl/div_req_seq.sv
`default_nettype none
// ============================================================================
//  Module   : div_req_seq
//  Purpose  : Request front-end for a restoring divider. Accepts an operand
//             pair, holds it on the divider operand bus, fires one init
//             pulse once the divider is idle, captures quotient/remainder on
//             the DONE rising edge and presents them on a valid/ready output.
//             A watchdog turns a missing DONE into a timeout error result.
//  Config   : DIV_ZERO_BYPASS_EN - when defined, a zero divisor skips the
//             divider and returns quot=all-ones, rem=dividend, err=2'b10.
//  Ports    : clk, rst (async, active-low)
//             in_valid/in_ready/in_a/in_b      - operand input handshake
//             div_idle/div_done/div_quot/div_rem - divider status/results
//             div_init/div_a/div_b             - divider launch and operands
//             out_valid/out_ready/out_quot/out_rem/out_err - result handshake
//  Revision : 1.0  initial release
// ============================================================================
module div_req_seq
    import div_pkg::*;
#(
    parameter int WIDTH   = 16,
    parameter int TIMEOUT = 64
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic             div_idle,
    input  logic             div_done,
    input  logic [WIDTH-1:0] div_quot,
    input  logic [WIDTH-1:0] div_rem,
    output logic             div_init,
    output logic [WIDTH-1:0] div_a,
    output logic [WIDTH-1:0] div_b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_quot,
    output logic [WIDTH-1:0] out_rem,
    output logic [1:0]       out_err
);

    state_t r_state;
    state_t w_next_state;
    logic   r_done_q;
    logic   w_done_rise;
    logic   w_expire;
    logic   w_accept;
    logic   w_bypass;

    assign in_ready = (r_state == IDLE);
    assign w_accept = in_valid && in_ready;

    // A DONE already high when BUSY is entered shows up in r_done_q, so only
    // a genuine low-to-high transition during BUSY counts as completion.
    assign w_done_rise = div_done && !r_done_q;

`ifdef DIV_ZERO_BYPASS_EN
    assign w_bypass = w_accept && (in_b == '0);
`else
    assign w_bypass = 1'b0;
`endif

    div_req_watchdog #(
        .TIMEOUT (TIMEOUT)
    ) u_watchdog (
        .clk    (clk),
        .rst    (rst),
        .clear  (r_state == LAUNCH),
        .enable (r_state == BUSY),
        .expire (w_expire)
    );

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            IDLE: begin
                if (w_accept) begin
                    w_next_state = w_bypass ? RESULT : WAIT_IDLE;
                end
            end
            // Waiting for DONE to drop as well as idle to rise keeps a
            // previous job's lingering DONE from being mistaken for ours.
            WAIT_IDLE: begin
                if (div_idle && !div_done) begin
                    w_next_state = LAUNCH;
                end
            end
            LAUNCH: begin
                w_next_state = BUSY;
            end
            BUSY: begin
                if (w_done_rise || w_expire) begin
                    w_next_state = RESULT;
                end
            end
            RESULT: begin
                if (out_ready) begin
                    w_next_state = IDLE;
                end
            end
            default: begin
                w_next_state = IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Registered outputs, operand and result registers, DONE history
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_done_q  <= 1'b0;
            div_init  <= 1'b0;
            out_valid <= 1'b0;
            div_a     <= '0;
            div_b     <= '0;
            out_quot  <= '0;
            out_rem   <= '0;
            out_err   <= ERR_NONE;
        end else begin
            r_done_q  <= div_done;
            div_init  <= (w_next_state == LAUNCH);
            out_valid <= (w_next_state == RESULT);

            if (w_accept) begin
                div_a <= in_a;
                div_b <= in_b;
            end

            // DONE edge takes priority over a simultaneous watchdog expiry.
            if (r_state == BUSY) begin
                if (w_done_rise) begin
                    out_quot <= div_quot;
                    out_rem  <= div_rem;
                    out_err  <= ERR_NONE;
                end else if (w_expire) begin
                    out_quot <= '0;
                    out_rem  <= '0;
                    out_err  <= ERR_TIMEOUT;
                end
            end

`ifdef DIV_ZERO_BYPASS_EN
            if (w_bypass) begin
                out_quot <= '1;
                out_rem  <= in_a;
                out_err  <= ERR_DIV0;
            end
`endif
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_div_req_seq.sv
`default_nettype none
// ============================================================================
//  Module   : tb_div_req_seq
//  Purpose  : Self-checking bench for div_req_seq. A behavioural divider
//             answers launches; expected results are pushed into a queue by
//             the stimulus and popped by a monitor on every output handshake.
//  Revision : 1.0  initial release
// ============================================================================
module tb_div_req_seq;

    localparam int WIDTH   = 16;
    localparam int TIMEOUT = 64;
    localparam int COMPUTE = 5;

    logic             clk;
    logic             rst;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_a;
    logic [WIDTH-1:0] in_b;
    logic             div_idle;
    logic             div_done;
    logic [WIDTH-1:0] div_quot;
    logic [WIDTH-1:0] div_rem;
    logic             div_init;
    logic [WIDTH-1:0] div_a;
    logic [WIDTH-1:0] div_b;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_quot;
    logic [WIDTH-1:0] out_rem;
    logic [1:0]       out_err;

    typedef struct packed {
        logic [WIDTH-1:0] q;
        logic [WIDTH-1:0] r;
        logic [1:0]       e;
    } res_t;

    res_t sb[$];
    int   checks = 0;
    int   errors = 0;
    int   init_cnt = 0;
    logic prev_init = 1'b0;
    logic [WIDTH-1:0] exp_a = '0;
    logic [WIDTH-1:0] exp_b = '0;

    // divider model controls
    logic model_clr;
    logic never_done;
    int   done_hold;
    int   m_phase;
    int   m_cnt;

    div_req_seq #(
        .WIDTH   (WIDTH),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_a      (in_a),
        .in_b      (in_b),
        .div_idle  (div_idle),
        .div_done  (div_done),
        .div_quot  (div_quot),
        .div_rem   (div_rem),
        .div_init  (div_init),
        .div_a     (div_a),
        .div_b     (div_b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_quot  (out_quot),
        .out_rem   (out_rem),
        .out_err   (out_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural divider: idle -> compute COMPUTE cycles -> DONE held done_hold cycles.
    always @(posedge clk) begin
        if (model_clr) begin
            m_phase  <= 0;
            m_cnt    <= 0;
            div_done <= 1'b0;
            div_idle <= 1'b1;
            div_quot <= '0;
            div_rem  <= '0;
        end else begin
            case (m_phase)
                0: if (div_init) begin
                    m_phase  <= 1;
                    m_cnt    <= COMPUTE;
                    div_idle <= 1'b0;
                    if (div_b == '0) begin
                        div_quot <= '1;
                        div_rem  <= div_a;
                    end else begin
                        div_quot <= div_a / div_b;
                        div_rem  <= div_a % div_b;
                    end
                end
                1: if (m_cnt > 0) begin
                    m_cnt <= m_cnt - 1;
                end else if (!never_done) begin
                    div_done <= 1'b1;
                    m_cnt    <= done_hold;
                    m_phase  <= 2;
                end
                2: if (m_cnt > 1) begin
                    m_cnt <= m_cnt - 1;
                end else begin
                    div_done <= 1'b0;
                    div_idle <= 1'b1;
                    m_phase  <= 0;
                end
                default: m_phase <= 0;
            endcase
        end
    end

    // Monitor: launch legality and scoreboard comparison on each result handshake.
    always @(negedge clk) begin
        if (rst) begin
            if (div_init) begin
                init_cnt++;
                check("launch_single_pulse", {31'd0, prev_init}, 32'd0);
                check("launch_div_idle_done", {30'd0, div_idle, div_done}, 32'b10);
                check("launch_div_a", {16'd0, div_a}, {16'd0, exp_a});
                check("launch_div_b", {16'd0, div_b}, {16'd0, exp_b});
            end
            prev_init = div_init;
            if (out_valid && out_ready) begin
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_result: got q=0x%0h r=0x%0h e=%0b expected none",
                             out_quot, out_rem, out_err);
                end else begin
                    res_t e;
                    e = sb.pop_front();
                    check("result_quot", {16'd0, out_quot}, {16'd0, e.q});
                    check("result_rem",  {16'd0, out_rem},  {16'd0, e.r});
                    check("result_err",  {30'd0, out_err},  {30'd0, e.e});
                end
            end
        end else begin
            prev_init = 1'b0;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
        int n;
        n = 0;
        while (!in_ready && n < 500) begin
            tick();
            n++;
        end
        if (!in_ready) begin
            checks++;
            errors++;
            $display("FAIL send_wait: got in_ready=0 expected 1 within 500 cycles");
        end
        exp_a    = a;
        exp_b    = b;
        in_a     = a;
        in_b     = b;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        // operands changing after accept must not reach the divider
        in_a     = 16'hDEAD;
        in_b     = 16'hBEEF;
    endtask

    task automatic push(input logic [WIDTH-1:0] q, input logic [WIDTH-1:0] r, input logic [1:0] e);
        res_t x;
        x.q = q;
        x.r = r;
        x.e = e;
        sb.push_back(x);
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (sb.size() != 0 && n < 1000) begin
            tick();
            n++;
        end
        check("drain_queue_empty", sb.size(), 32'd0);
    endtask

    task automatic wait_init(output int ok);
        int n;
        n = 0;
        while (!div_init && n < 200) begin
            tick();
            n++;
        end
        ok = div_init ? 1 : 0;
        check("wait_div_init", {31'd0, div_init}, 32'd1);
    endtask

    initial begin
        int ok;
        int n;
        int i0;

        rst        = 1'b0;
        model_clr  = 1'b1;
        never_done = 1'b0;
        done_hold  = 3;
        in_valid   = 1'b0;
        in_a       = '0;
        in_b       = '0;
        out_ready  = 1'b1;
        repeat (3) tick();

        // reset state
        check("reset_outputs", {div_init, out_valid, out_err, div_a, div_b},
              {1'b0, 1'b0, 2'b00, 16'd0, 16'd0});
        check("reset_results", {out_quot, out_rem}, 32'd0);
        check("reset_in_ready", {31'd0, in_ready}, 32'd1);
        rst       = 1'b1;
        model_clr = 1'b0;
        tick();

        // 1: single job 100/7
        push(16'd14, 16'd2, 2'b00);
        send(16'd100, 16'd7);
        drain();
        check("t1_init_count", init_cnt, 32'd1);

        // 2: back-to-back with long DONE hold
        done_hold = 21;
        push(16'd10, 16'd0, 2'b00);
        send(16'd50, 16'd5);
        push(16'd2, 16'd1, 2'b00);
        send(16'd9, 16'd4);
        drain();
        check("t2_init_count", init_cnt, 32'd3);
        done_hold = 3;
        repeat (30) tick();

        // 3: DONE never arrives -> timeout; LAUNCH cycle plus TIMEOUT busy cycles
        never_done = 1'b1;
        push(16'd0, 16'd0, 2'b01);
        send(16'd77, 16'd3);
        wait_init(ok);
        n = 0;
        while (!out_valid && n < 300) begin
            tick();
            n++;
        end
        check("t3_timeout_latency", n, 32'd65);
        drain();
        model_clr  = 1'b1;
        tick();
        model_clr  = 1'b0;
        never_done = 1'b0;

        // 4: consumer stalls 10 cycles in RESULT while new input is offered
        out_ready = 1'b0;
        push(16'd22, 16'd2, 2'b00);
        send(16'd200, 16'd9);
        n = 0;
        while (!out_valid && n < 200) begin
            tick();
            n++;
        end
        i0       = init_cnt;
        in_valid = 1'b1;
        in_a     = 16'd1;
        in_b     = 16'd1;
        for (int k = 0; k < 10; k++) begin
            tick();
            check("t4_hold_valid_quot_rem", {out_valid, out_quot, out_rem[14:0]},
                  {1'b1, 16'd22, 15'd2});
            check("t4_in_ready_low", {31'd0, in_ready}, 32'd0);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        drain();
        repeat (5) tick();
        check("t4_no_second_launch", init_cnt, i0);

        // 5: reset while BUSY aborts with no result
        send(16'd1234, 16'd56);
        wait_init(ok);
        repeat (3) tick();
        rst = 1'b0;
        #1;
        check("t5_reset_outputs", {div_init, out_valid, out_err, div_a, div_b},
              {1'b0, 1'b0, 2'b00, 16'd0, 16'd0});
        check("t5_reset_results", {out_quot, out_rem}, 32'd0);
        check("t5_in_ready_in_reset", {31'd0, in_ready}, 32'd1);
        model_clr = 1'b1;
        tick();
        tick();
        rst       = 1'b1;
        model_clr = 1'b0;
        tick();
        check("t5_in_ready_after", {31'd0, in_ready}, 32'd1);
        repeat (100) tick();
        check("t5_no_result", {31'd0, out_valid}, 32'd0);

        // 6: zero divisor
        i0 = init_cnt;
`ifdef DIV_ZERO_BYPASS_EN
        push(16'hFFFF, 16'd37, 2'b10);
        send(16'd37, 16'd0);
        drain();
        check("t6_no_launch", init_cnt, i0);
`else
        push(16'hFFFF, 16'd37, 2'b00);
        send(16'd37, 16'd0);
        drain();
        check("t6_launched", init_cnt, i0 + 1);
`endif

        repeat (10) tick();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1);
    end

endmodule
`default_nettype wire
